mux_nx1_flop_rr: RTL and testbench

// - Parametrised N-to-1 registered mux; successor to the 2-bit Mux_2x1 + FLOP_D pair.
// - Selects one of CHANNELS input words, each WIDTH bits wide, by fixed selector (MODE=0) or round-robin among valid channels (MODE=1).
// - Output held in one register stage with a valid/ready handshake.
// - Sits between component-level sources and any downstream consumer that can stall.

---
 rtl/mux_nx1_flop_rr.sv | 155 +++++++++++++++
 tb/tb_mux_nx1_flop_rr.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_flop_rr.sv
// ----------------------------------------------------------------------------
// mux_nx1_flop_rr
//
// Parametrised N-to-1 registered multiplexer with a valid/ready handshake on
// both sides. It replaces the older 2-bit Mux_2x1 + FLOP_D pair.
//
// One of CHANNELS input words (each WIDTH bits) is chosen and captured in a
// single output register stage. The channel is chosen either:
//   MODE = 0 : by the external selector (only if that channel is valid), or
//   MODE = 1 : by round-robin arbitration among the valid channels. The search
//              starts just after the last granted channel and wraps around.
//
// The output register reloads whenever it is empty or being drained
// (load_en = !valid_out || ready_out). So with ready_out held high it accepts
// a new word every cycle.
//
// Ports
//   clok       in   1               clock, all state updates on posedge
//   reset      in   1               synchronous, active-high reset
//   data_in    in   CHANNELS*WIDTH  channel i word at [i*WIDTH +: WIDTH]
//   valid_in   in   CHANNELS        channel i has a word available
//   ready_in   out  CHANNELS        one-hot, channel i word consumed this cycle
//   selector   in   SELW            requested channel (MODE = 0 only)
//   data_out   out  WIDTH           registered selected word
//   sel_out    out  SELW            channel index that produced data_out
//   valid_out  out  1               data_out/sel_out hold a word
//   ready_out  in   1               downstream accepts data_out this cycle
// ----------------------------------------------------------------------------
module mux_nx1_flop_rr #(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = 0,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clok,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_in,
  input  logic [SELW-1:0]           selector,
  output logic [WIDTH-1:0]          data_out,
  output logic [SELW-1:0]           sel_out,
  output logic                      valid_out,
  input  logic                      ready_out
);

  // Output register stage and arbitration state.
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;
  logic             r_valid;
  logic [SELW-1:0]  r_rr_ptr;   // last granted channel (MODE = 1)

  // Grant candidates from both policies; MODE picks one of them.
  logic             w_fix_gnt;
  logic [SELW-1:0]  w_fix_idx;
  logic             w_rr_gnt;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_gnt;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_mux_data;
  logic             w_load_en;

  assign w_load_en = !r_valid || ready_out;

  // Fixed selection. Comparing against every legal index means an
  // out-of-range selector (non-power-of-2 CHANNELS) just matches nothing.
  // No variable index is used, so no X can propagate.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch.
    // A path that leaves it unassigned would infer a latch.
    w_fix_gnt = 1'b0;
    w_fix_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (selector == SELW'(i) && valid_in[i]) begin
        w_fix_gnt = 1'b1;
        w_fix_idx = SELW'(i);
      end
    end
  end

  // Round-robin selection. Each channel gets a search position: the distance
  // after r_rr_ptr, minus one. So r_rr_ptr+1 has position 0, and r_rr_ptr
  // itself has position CHANNELS-1 and is searched last. The valid channel
  // with the smallest position wins.
  always_comb begin
    int best_pos;
    int pos;
    w_rr_gnt = 1'b0;
    w_rr_idx = '0;
    best_pos = CHANNELS;
    pos      = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      pos = i - int'(r_rr_ptr) - 1;
      if (pos < 0) begin
        pos = pos + CHANNELS;
      end
      if (valid_in[i] && pos < best_pos) begin
        best_pos = pos;
        w_rr_gnt = 1'b1;
        w_rr_idx = SELW'(i);
      end
    end
  end

  assign w_gnt     = (MODE == 1) ? w_rr_gnt : w_fix_gnt;
  assign w_gnt_idx = (MODE == 1) ? w_rr_idx : w_fix_idx;

  // Data mux on the granted channel. Constant part-selects only.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt_idx == SELW'(i)) begin
        w_mux_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // A channel is consumed only when the register really loads this cycle.
  // Held low during reset so a source never sees its word taken and then lost.
  always_comb begin
    ready_in = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ready_in[i] = !reset && w_load_en && w_gnt && (w_gnt_idx == SELW'(i));
    end
  end

  always_ff @(posedge clok) begin
    // NOTE: state is updated with non-blocking assignments. All registers then
    // sample the pre-edge values, whatever order the statements are in.
    if (reset) begin
      r_data   <= '0;
      r_sel    <= '0;
      r_valid  <= 1'b0;
      r_rr_ptr <= SELW'(CHANNELS - 1);
    end else if (w_load_en) begin
      if (w_gnt) begin
        r_data  <= w_mux_data;
        r_sel   <= w_gnt_idx;
        r_valid <= 1'b1;
        // Fairness advances only on an accepted load, never during a stall.
        if (MODE == 1) begin
          r_rr_ptr <= w_gnt_idx;
        end
      end else begin
        // Nothing to load: drop valid_out but keep the last word and index.
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out  = r_data;
  assign sel_out   = r_sel;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_mux_nx1_flop_rr.sv
// ----------------------------------------------------------------------------
// tb_mux_nx1_flop_rr
//
// Self-checking bench for mux_nx1_flop_rr. It drives three instances:
//   u_dut0 : WIDTH=2, CHANNELS=4, MODE=0 (selector driven, vector table)
//   u_dut1 : WIDTH=2, CHANNELS=4, MODE=1 (round-robin sequences)
//   u_dut2 : WIDTH=2, CHANNELS=3, MODE=0 (out-of-range selector)
// Inputs change on the falling edge. ready_in is sampled 1 ns later, before
// the rising edge. Registered outputs are sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_mux_nx1_flop_rr;

  logic clk;

  // Instance 0: MODE = 0, 4 channels
  logic       rst0;
  logic [7:0] data0;
  logic [3:0] vin0;
  logic [3:0] rdy0;
  logic [1:0] sel0;
  logic [1:0] dout0;
  logic [1:0] so0;
  logic       vo0;
  logic       rout0;

  // Instance 1: MODE = 1, 4 channels
  logic       rst1;
  logic [7:0] data1;
  logic [3:0] vin1;
  logic [3:0] rdy1;
  logic [1:0] sel1;
  logic [1:0] dout1;
  logic [1:0] so1;
  logic       vo1;
  logic       rout1;

  // Instance 2: MODE = 0, 3 channels (selector value 3 is out of range)
  logic       rst2;
  logic [5:0] data2;
  logic [2:0] vin2;
  logic [2:0] rdy2;
  logic [1:0] sel2;
  logic [1:0] dout2;
  logic [1:0] so2;
  logic       vo2;
  logic       rout2;

  int n_checks = 0;
  int n_errors = 0;

  mux_nx1_flop_rr #(.WIDTH(2), .CHANNELS(4), .MODE(0)) u_dut0 (
    .clok(clk), .reset(rst0), .data_in(data0), .valid_in(vin0),
    .ready_in(rdy0), .selector(sel0), .data_out(dout0), .sel_out(so0),
    .valid_out(vo0), .ready_out(rout0)
  );

  mux_nx1_flop_rr #(.WIDTH(2), .CHANNELS(4), .MODE(1)) u_dut1 (
    .clok(clk), .reset(rst1), .data_in(data1), .valid_in(vin1),
    .ready_in(rdy1), .selector(sel1), .data_out(dout1), .sel_out(so1),
    .valid_out(vo1), .ready_out(rout1)
  );

  mux_nx1_flop_rr #(.WIDTH(2), .CHANNELS(3), .MODE(0)) u_dut2 (
    .clok(clk), .reset(rst2), .data_in(data2), .valid_in(vin2),
    .ready_in(rdy2), .selector(sel2), .data_out(dout2), .sel_out(so2),
    .valid_out(vo2), .ready_out(rout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of the MODE = 0 table: drive inputs, check ready_in before the
  // edge, then check the registered outputs after the edge.
  typedef struct {
    logic [1:0] sel;
    logic [3:0] vin;
    logic       rout;
    logic [3:0] exp_rdy;
    logic [1:0] exp_dout;
    logic [1:0] exp_so;
    logic       exp_vo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int rr_seq[6];
    int bp_seq[4];
    int prev;

    // sel, vin, rout | ready_in, data_out, sel_out, valid_out (after edge)
    vecs[0] = '{2'd2, 4'b1111, 1'b1, 4'b0100, 2'b10, 2'd2, 1'b1}; // plain select ch2
    vecs[1] = '{2'd1, 4'b1111, 1'b0, 4'b0000, 2'b10, 2'd2, 1'b1}; // stall, selector moved
    vecs[2] = '{2'd1, 4'b1111, 1'b0, 4'b0000, 2'b10, 2'd2, 1'b1}; // stall
    vecs[3] = '{2'd1, 4'b1111, 1'b0, 4'b0000, 2'b10, 2'd2, 1'b1}; // stall
    vecs[4] = '{2'd1, 4'b1111, 1'b1, 4'b0010, 2'b01, 2'd1, 1'b1}; // release -> ch1
    vecs[5] = '{2'd3, 4'b0111, 1'b1, 4'b0000, 2'b01, 2'd1, 1'b0}; // selected ch invalid
    vecs[6] = '{2'd3, 4'b1000, 1'b0, 4'b1000, 2'b11, 2'd3, 1'b1}; // empty reg loads despite ready_out=0
    vecs[7] = '{2'd0, 4'b1111, 1'b1, 4'b0001, 2'b00, 2'd0, 1'b1}; // accept + reload same cycle
    vecs[8] = '{2'd0, 4'b1110, 1'b0, 4'b0000, 2'b00, 2'd0, 1'b1}; // stall
    vecs[9] = '{2'd0, 4'b1110, 1'b1, 4'b0000, 2'b00, 2'd0, 1'b0}; // drain, no grant

    rst0  = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    data0 = 8'b11_10_01_00; vin0 = 4'b1111; sel0 = 2'd2; rout0 = 1'b1;
    data1 = 8'b11_10_01_00; vin1 = 4'b1111; sel1 = 2'd0; rout1 = 1'b1;
    data2 = 6'b11_10_01;    vin2 = 3'b111;  sel2 = 2'd0; rout2 = 1'b1;

    // T1: reset held for two cycles with every channel valid.
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("t1 c%0d ready_in", c), 32'(rdy0), 32'h0);
      check($sformatf("t1 c%0d rr ready_in", c), 32'(rdy1), 32'h0);
      @(posedge clk); #1;
      check($sformatf("t1 c%0d valid_out", c), 32'(vo0), 32'h0);
      check($sformatf("t1 c%0d data_out", c), 32'(dout0), 32'h0);
      check($sformatf("t1 c%0d sel_out", c), 32'(so0), 32'h0);
      @(negedge clk);
    end
    rst0 = 1'b0;
    rst2 = 1'b0;

    // T2/T3 plus further MODE = 0 cases from the table.
    for (int i = 0; i < 10; i++) begin
      sel0  = vecs[i].sel;
      vin0  = vecs[i].vin;
      rout0 = vecs[i].rout;
      #1;
      check($sformatf("v%0d ready_in", i), 32'(rdy0), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d data_out", i), 32'(dout0), 32'(vecs[i].exp_dout));
      check($sformatf("v%0d sel_out", i), 32'(so0), 32'(vecs[i].exp_so));
      check($sformatf("v%0d valid_out", i), 32'(vo0), 32'(vecs[i].exp_vo));
      @(negedge clk);
    end

    // u_dut2 has been granting ch0 (data 01) every cycle since reset released.
    // Out-of-range selector: no grant, valid drops, word and index kept.
    sel2 = 2'd3;
    #1;
    check("oor1 ready_in", 32'(rdy2), 32'h0);
    @(posedge clk); #1;
    check("oor1 valid_out", 32'(vo2), 32'h0);
    check("oor1 data_out", 32'(dout2), 32'h1);
    check("oor1 sel_out", 32'(so2), 32'h0);
    @(negedge clk);
    sel2 = 2'd2;
    #1;
    check("oor2 ready_in", 32'(rdy2), 32'h4);
    @(posedge clk); #1;
    check("oor2 valid_out", 32'(vo2), 32'h1);
    check("oor2 data_out", 32'(dout2), 32'h3);
    check("oor2 sel_out", 32'(so2), 32'h2);
    @(negedge clk);
    sel2 = 2'd3;
    #1;
    check("oor3 ready_in", 32'(rdy2), 32'h0);
    @(posedge clk); #1;
    check("oor3 valid_out", 32'(vo2), 32'h0);
    check("oor3 data_out", 32'(dout2), 32'h3);
    check("oor3 sel_out", 32'(so2), 32'h2);
    @(negedge clk);

    // T4: round-robin fairness with channel 2 never valid.
    // rr_ptr is reset to 3, so the search starts at channel 0.
    rr_seq = '{0, 1, 3, 0, 1, 3};
    rst1  = 1'b0;
    vin1  = 4'b1011;
    rout1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("t4 k%0d ready_in", k), 32'(rdy1), 32'(1) << rr_seq[k]);
      @(posedge clk); #1;
      check($sformatf("t4 k%0d sel_out", k), 32'(so1), 32'(rr_seq[k]));
      check($sformatf("t4 k%0d data_out", k), 32'(dout1), 32'(rr_seq[k]));
      check($sformatf("t4 k%0d valid_out", k), 32'(vo1), 32'h1);
      @(negedge clk);
    end

    // T5: alternate stall / accept. Stalls must not advance the pointer, so
    // the grant order continues exactly where T4 stopped (last grant 3).
    bp_seq = '{0, 1, 3, 0};
    prev   = 3;
    for (int k = 0; k < 4; k++) begin
      rout1 = 1'b0;
      #1;
      check($sformatf("t5 k%0d stall ready_in", k), 32'(rdy1), 32'h0);
      @(posedge clk); #1;
      check($sformatf("t5 k%0d stall sel_out", k), 32'(so1), 32'(prev));
      check($sformatf("t5 k%0d stall valid_out", k), 32'(vo1), 32'h1);
      @(negedge clk);
      rout1 = 1'b1;
      #1;
      check($sformatf("t5 k%0d ready_in", k), 32'(rdy1), 32'(1) << bp_seq[k]);
      @(posedge clk); #1;
      check($sformatf("t5 k%0d sel_out", k), 32'(so1), 32'(bp_seq[k]));
      prev = bp_seq[k];
      @(negedge clk);
    end

    // Load channel 2 so that a non-zero word and index are held.
    // rr_ptr becomes 2.
    vin1 = 4'b0100;
    #1;
    check("pre6 ready_in", 32'(rdy1), 32'h4);
    @(posedge clk); #1;
    check("pre6 sel_out", 32'(so1), 32'h2);
    check("pre6 data_out", 32'(dout1), 32'h2);
    @(negedge clk);

    // T6: reset while a word is held and stalled.
    rout1 = 1'b0;
    rst1  = 1'b1;
    vin1  = 4'b1001;
    #1;
    check("t6 reset ready_in", 32'(rdy1), 32'h0);
    @(posedge clk); #1;
    check("t6 valid_out", 32'(vo1), 32'h0);
    check("t6 data_out", 32'(dout1), 32'h0);
    check("t6 sel_out", 32'(so1), 32'h0);
    @(negedge clk);
    // rr_ptr is back to 3, so channel 0 wins. A stale pointer of 2 would pick 3.
    rst1  = 1'b0;
    rout1 = 1'b1;
    #1;
    check("t6 first ready_in", 32'(rdy1), 32'h1);
    @(posedge clk); #1;
    check("t6 first sel_out", 32'(so1), 32'h0);
    check("t6 first valid_out", 32'(vo1), 32'h1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
